wb_port_arbiter: RTL and testbench

- Shares the single register-file write port (busW/Rw/RegWr) between two sources:
  - the pipelined Wr (write-back) stage;
  - the multi-cycle multiply/divide unit (MDU), whose results complete out of band.
- Pipeline writes have priority. MDU results queue in a small FIFO and drain in idle write-port cycles.
- A starvation counter forces a one-cycle pipeline hold so queued MDU results cannot wait indefinitely.
- Exports a busy scoreboard so decode can stall on registers with a pending MDU write.

---
 rtl/wb_port_arbiter_pkg.sv | 27 ++
 rtl/mdu_result_fifo.sv | 82 ++++++++
 rtl/wb_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [REG_W-1:0] REG_ZERO = '0;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_W-1:0]  rw;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Which source owns the write port this cycle.
    typedef enum logic [1:0] {
        GntNone,
        GntPipe,
        GntFifo
    } gnt_e;

    // A destination of $0 never needs the port.
    function automatic logic is_real_reg(input logic [REG_W-1:0] rw);
        return rw != REG_ZERO;
    endfunction

endpackage

// File: rtl/mdu_result_fifo.sv
// Circular queue of MDU results waiting for a free register-file write cycle.
// Per-entry valid/rw are exported so the top can build the busy scoreboard.
module mdu_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wb_req_t                      push_req,
    input  logic                         pop,
    output wb_req_t                      head,
    output logic                         empty,
    output logic                         full,
    output logic [CNT_W-1:0]             count,
    output logic [DEPTH-1:0]             ent_valid,
    output logic [DEPTH-1:0][REG_W-1:0]  ent_rw
);

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy next state; DEPTH is a power of two so pointers wrap naturally.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_req;
        end
    end

    // Slot i is live when its distance from the read pointer is below the count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [PTR_W-1:0] offs;
        assign offs         = PTR_W'(i) - rd_ptr_q;
        assign ent_valid[i] = {1'b0, offs} < count_q;
        assign ent_rw[i]    = mem_q[i].rw;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between the Wr stage and
// queued MDU results. The pipeline wins unless a queued result has waited
// STARVE_MAX cycles, in which case the pipeline is held for one cycle.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_regwr,
    input  logic [REG_W-1:0]  pipe_rw,
    input  logic [DATA_W-1:0] pipe_busW,
    input  logic              mdu_valid,
    input  logic [REG_W-1:0]  mdu_rw,
    input  logic [DATA_W-1:0] mdu_data,
    output logic              mdu_ready,
    output logic              pipe_hold,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_rw,
    output logic [DATA_W-1:0] rf_busW,
    input  logic [REG_W-1:0]  chk_rs,
    input  logic [REG_W-1:0]  chk_rt,
    output logic              rs_busy,
    output logic              rt_busy
);

    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0]  STARVE_LIM = 4'(STARVE_MAX);

    logic                               pipe_req;
    logic                               fifo_push;
    logic                               fifo_pop;
    wb_req_t                            fifo_in;
    wb_req_t                            fifo_head;
    logic                               fifo_empty;
    logic                               fifo_full;
    logic [CNT_W-1:0]                   fifo_count;
    logic [FIFO_DEPTH-1:0]              ent_valid;
    logic [FIFO_DEPTH-1:0][REG_W-1:0]   ent_rw;
    logic                               empty_next;
    logic                               force_wr;
    gnt_e                               gnt;
    logic [3:0]                         cnt_q, cnt_d;

    assign pipe_req  = pipe_regwr && is_real_reg(pipe_rw);
    assign mdu_ready = !rst && !fifo_full;
    // Results for $0 complete the handshake but are dropped here.
    assign fifo_push = mdu_valid && mdu_ready && is_real_reg(mdu_rw);
    assign fifo_in   = '{rw: mdu_rw, data: mdu_data};
    assign fifo_pop  = (gnt == GntFifo);
    assign force_wr  = !rst && !fifo_empty && (cnt_q == STARVE_LIM);

    mdu_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_req  (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count),
        .ent_valid (ent_valid),
        .ent_rw    (ent_rw)
    );

    // Pick the port owner: starved queue first, then pipeline, then idle-cycle drain.
    always_comb begin
        gnt       = GntNone;
        pipe_hold = 1'b0;
        if (!rst) begin
            if (force_wr) begin
                gnt       = GntFifo;
                pipe_hold = 1'b1;
            end else if (pipe_req) begin
                gnt = GntPipe;
            end else if (!fifo_empty) begin
                gnt = GntFifo;
            end
        end
    end

    // Drive the register-file write port from the granted source.
    always_comb begin
        rf_we   = 1'b0;
        rf_rw   = REG_ZERO;
        rf_busW = '0;
        unique case (gnt)
            GntPipe: begin
                rf_we   = 1'b1;
                rf_rw   = pipe_rw;
                rf_busW = pipe_busW;
            end
            GntFifo: begin
                rf_we   = 1'b1;
                rf_rw   = fifo_head.rw;
                rf_busW = fifo_head.data;
            end
            default: begin
            end
        endcase
    end

    // Starvation counter next state, based on the queue occupancy after this edge.
    always_comb begin
        if (fifo_empty) begin
            empty_next = !fifo_push;
        end else begin
            empty_next = (fifo_count == CNT_W'(1)) && fifo_pop && !fifo_push;
        end

        if (fifo_pop || empty_next) begin
            cnt_d = '0;
        end else if (cnt_q < STARVE_LIM) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Busy scoreboard: a queued entry stays busy through the cycle it is written.
    always_comb begin
        rs_busy = 1'b0;
        rt_busy = 1'b0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (ent_valid[i] && ent_rw[i] == chk_rs) begin
                rs_busy = 1'b1;
            end
            if (ent_valid[i] && ent_rw[i] == chk_rt) begin
                rt_busy = 1'b1;
            end
        end
        if (rst || !is_real_reg(chk_rs)) begin
            rs_busy = 1'b0;
        end
        if (rst || !is_real_reg(chk_rt)) begin
            rt_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a directed vector table, hand-written corner
// sequences, and a randomized run, all against a queue-based reference model.
module tb_wb_port_arbiter;
    import wb_port_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_regwr;
    logic [4:0]  pipe_rw;
    logic [31:0] pipe_busW;
    logic        mdu_valid;
    logic [4:0]  mdu_rw;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        pipe_hold;
    logic        rf_we;
    logic [4:0]  rf_rw;
    logic [31:0] rf_busW;
    logic [4:0]  chk_rs;
    logic [4:0]  chk_rt;
    logic        rs_busy;
    logic        rt_busy;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_regwr (pipe_regwr),
        .pipe_rw    (pipe_rw),
        .pipe_busW  (pipe_busW),
        .mdu_valid  (mdu_valid),
        .mdu_rw     (mdu_rw),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .pipe_hold  (pipe_hold),
        .rf_we      (rf_we),
        .rf_rw      (rf_rw),
        .rf_busW    (rf_busW),
        .chk_rs     (chk_rs),
        .chk_rt     (chk_rt),
        .rs_busy    (rs_busy),
        .rt_busy    (rt_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: pending MDU writes in arrival order plus a wait counter.
    typedef struct {
        logic [4:0]  rw;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];
    int   cnt = 0;

    logic        e_ready, e_hold, e_we, e_rs, e_rt, e_pop;
    logic [4:0]  e_rw;
    logic [31:0] e_data;
    logic        s_ready, s_hold, s_we, s_rs, s_rt;
    logic [4:0]  s_rw;
    logic [31:0] s_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit in_q(input logic [4:0] r);
        foreach (q[i]) if (q[i].rw == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void model_expect();
        bit preq;
        bit frc;
        preq    = pipe_regwr && pipe_rw != 5'd0;
        e_ready = !rst && q.size() < DEPTH;
        e_hold  = 1'b0;
        e_we    = 1'b0;
        e_rw    = 5'd0;
        e_data  = 32'd0;
        e_pop   = 1'b0;
        e_rs    = !rst && chk_rs != 5'd0 && in_q(chk_rs);
        e_rt    = !rst && chk_rt != 5'd0 && in_q(chk_rt);
        if (!rst) begin
            frc = q.size() > 0 && cnt == SMAX;
            if (frc) begin
                e_we = 1'b1; e_hold = 1'b1; e_rw = q[0].rw; e_data = q[0].data; e_pop = 1'b1;
            end else if (preq) begin
                e_we = 1'b1; e_rw = pipe_rw; e_data = pipe_busW;
            end else if (q.size() > 0) begin
                e_we = 1'b1; e_rw = q[0].rw; e_data = q[0].data; e_pop = 1'b1;
            end
        end
    endfunction

    function automatic void model_update();
        ent_t e;
        if (rst) begin
            q.delete();
            cnt = 0;
        end else begin
            if (e_pop) void'(q.pop_front());
            if (mdu_valid && e_ready && mdu_rw != 5'd0) begin
                e.rw   = mdu_rw;
                e.data = mdu_data;
                q.push_back(e);
            end
            if (e_pop || q.size() == 0) cnt = 0;
            else if (cnt < SMAX) cnt++;
        end
    endfunction

    // One clock: predict, sample mid-cycle, compare, then advance the model at the edge.
    task automatic run_cycle(input string tag);
        model_expect();
        if (!rst && pipe_regwr && pipe_rw != 5'd0)
            check({tag, ".waw"}, 64'(in_q(pipe_rw)), 64'(0));
        @(negedge clk);
        s_ready = mdu_ready; s_hold = pipe_hold; s_we = rf_we; s_rw = rf_rw;
        s_data = rf_busW; s_rs = rs_busy; s_rt = rt_busy;
        check({tag, ".out"}, 64'({s_ready, s_hold, s_we, s_rw, s_data, s_rs, s_rt}),
              64'({e_ready, e_hold, e_we, e_rw, e_data, e_rs, e_rt}));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; pipe_regwr = 1'b0; pipe_rw = 5'd0; pipe_busW = 32'd0;
        mdu_valid = 1'b0; mdu_rw = 5'd0; mdu_data = 32'd0; chk_rs = 5'd0; chk_rt = 5'd0;
    endtask

    typedef struct {
        logic        rst, regwr;
        logic [4:0]  prw;
        logic [31:0] pdata;
        logic        mv;
        logic [4:0]  mrw;
        logic [31:0] mdata;
        logic [4:0]  crs, crt;
        logic        ready, hold, we;
        logic [4:0]  rw;
        logic [31:0] data;
        logic        rs, rt;
    } vec_t;
    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit       held;
        bit       saw_block;
        int       sent, got, k;
        logic [4:0]  exp_rw[6];
        logic        exp_hold[6];
        logic        exp_busy[6];

        vecs[0]  = '{1'b1, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 5'd0,
                     1'b0, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd8, 5'd0,
                     1'b1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd8, 32'h1234, 5'd8, 5'd0,
                     1'b1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd8, 5'd8,
                     1'b1, 1'b0, 1'b1, 5'd8, 32'h1234, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd8, 5'd0,
                     1'b1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'h33,   5'd0, 5'd0,
                     1'b1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'h0,    5'd0, 5'd3,
                     1'b1, 1'b0, 1'b1, 5'd3, 32'h33,   1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'h77,   5'd0, 5'd0,
                     1'b1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd0, 5'd0,
                     1'b1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 5'd9, 32'habc,  1'b0, 5'd0, 32'h0,    5'd0, 5'd0,
                     1'b1, 1'b0, 1'b1, 5'd9, 32'habc,  1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 5'd9, 32'habc,  1'b0, 5'd0, 32'h0,    5'd0, 5'd0,
                     1'b1, 1'b0, 1'b0, 5'd0, 32'h0,    1'b0, 1'b0};

        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        model_update();
        #1;

        // Directed table: reset, lone MDU result, $0 handling, plain pipe writes.
        foreach (vecs[i]) begin
            rst = vecs[i].rst; pipe_regwr = vecs[i].regwr; pipe_rw = vecs[i].prw;
            pipe_busW = vecs[i].pdata; mdu_valid = vecs[i].mv; mdu_rw = vecs[i].mrw;
            mdu_data = vecs[i].mdata; chk_rs = vecs[i].crs; chk_rt = vecs[i].crt;
            run_cycle($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tbl", i),
                  64'({s_ready, s_hold, s_we, s_rw, s_data, s_rs, s_rt}),
                  64'({vecs[i].ready, vecs[i].hold, vecs[i].we, vecs[i].rw, vecs[i].data,
                       vecs[i].rs, vecs[i].rt}));
        end

        // Contention: one queued result waits out the starvation limit behind rw=9.
        exp_rw   = '{5'd9, 5'd9, 5'd9, 5'd9, 5'd10, 5'd9};
        exp_hold = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        idle_inputs();
        pipe_regwr = 1'b1; pipe_rw = 5'd9; pipe_busW = 32'h900;
        mdu_valid = 1'b1; mdu_rw = 5'd10; mdu_data = 32'ha0a0; chk_rs = 5'd10;
        for (int c = 0; c < 6; c++) begin
            run_cycle("cont");
            mdu_valid = 1'b0;
            check($sformatf("cont%0d.rw", c), 64'(s_rw), 64'(exp_rw[c]));
            check($sformatf("cont%0d.hold", c), 64'(s_hold), 64'(exp_hold[c]));
            check($sformatf("cont%0d.data", c), 64'(s_data),
                  (c == 4) ? 64'h0000_a0a0 : 64'h0000_0900);
            check($sformatf("cont%0d.busy", c), 64'(s_rs), 64'(exp_busy[c]));
        end

        // Full queue and pointer wrap: five results drain in order behind a busy pipe.
        idle_inputs();
        sent = 0; got = 0; k = 0; saw_block = 1'b0;
        mdu_valid = 1'b1; mdu_rw = 5'd1; mdu_data = 32'h101;
        for (int c = 0; c < 80 && got < 5; c++) begin
            pipe_regwr = 1'b1; pipe_rw = 5'd20; pipe_busW = 32'h2000 + 32'(k);
            run_cycle("full");
            if (mdu_valid && !s_ready) saw_block = 1'b1;
            if (s_we && s_rw != 5'd20) begin
                check($sformatf("full.order%0d", got), 64'({s_rw, s_data}),
                      64'({5'(got + 1), 32'h100 + 32'(got + 1)}));
                got++;
            end
            if (mdu_valid && s_ready) begin
                sent++;
                if (sent < 5) begin
                    mdu_rw = 5'(sent + 1); mdu_data = 32'h100 + 32'(sent + 1);
                end else begin
                    mdu_valid = 1'b0;
                end
            end
            if (!s_hold) k++;
        end
        check("full.blocked", 64'(saw_block), 64'(1));
        check("full.drained", 64'(got), 64'(5));

        // Reset with two entries queued: no write in the reset cycle, clean afterwards.
        idle_inputs();
        for (int c = 0; c < 10 && q.size() > 0; c++) run_cycle("flush");
        pipe_regwr = 1'b1; pipe_rw = 5'd20; pipe_busW = 32'h55;
        mdu_valid = 1'b1; mdu_rw = 5'd6; mdu_data = 32'h66;
        run_cycle("rst.fill0");
        mdu_rw = 5'd7; mdu_data = 32'h77;
        run_cycle("rst.fill1");
        mdu_valid = 1'b0; rst = 1'b1; chk_rs = 5'd6; chk_rt = 5'd7;
        run_cycle("rst.mid");
        check("rst.mid.we", 64'(s_we), 64'(0));
        check("rst.mid.ready", 64'(s_ready), 64'(0));
        idle_inputs();
        chk_rs = 5'd6; chk_rt = 5'd7;
        run_cycle("rst.after");
        check("rst.after.we", 64'(s_we), 64'(0));
        check("rst.after.busy", 64'({s_rs, s_rt}), 64'(0));
        check("rst.after.ready", 64'(s_ready), 64'(1));
        check("rst.after.cnt", 64'(dut.cnt_q), 64'(0));

        // Randomized traffic; pipe and MDU use disjoint registers, as decode would enforce.
        idle_inputs();
        held = 1'b0;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            if (!held) begin
                pipe_regwr = 1'($urandom_range(0, 1));
                pipe_rw    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
                pipe_busW  = $urandom;
            end
            if (!mdu_valid) begin
                mdu_valid = ($urandom_range(0, 2) == 0);
                mdu_rw    = 5'($urandom_range(0, 15));
                mdu_data  = $urandom;
            end
            chk_rs = 5'($urandom_range(0, 15));
            chk_rt = 5'($urandom_range(0, 15));
            run_cycle("rand");
            held = s_hold;
            if (rst || (mdu_valid && s_ready)) mdu_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
